// File: rtl/fetch_controller_if.sv
// Fetch bus bundle: memory address/data, redirect request and the decode
// valid/ready handshake. master = fetch controller, slave = memory/decode side.
interface fetch_controller_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output mem_addr, out_valid, out_instr, out_pc,
    input  mem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_addr, out_valid, out_instr, out_pc,
    output mem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer for a synchronous-read instruction memory.
// Issues one word address per cycle under a 2-entry credit, captures the
// returned word a cycle later into a 2-deep FIFO, and hands words to decode
// over valid/ready. Redirects flush and retarget; HALT_WORD stops fetching.
module fetch_controller #(
  parameter int                 ADDR_W    = 10,
  parameter int                 DATA_W    = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [DATA_W-1:0]  HALT_WORD = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  fetch_controller_if.master bus,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;

  logic [1:0][DATA_W-1:0] fifo_instr;
  logic [1:0][ADDR_W-1:0] fifo_pc;
  logic                   rd_ptr, wr_ptr;
  logic [1:0]             count;

  logic pop, push, ret_live, halt_hit, issue_en, flush, restart;

  assign bus.out_valid = (count != 2'd0);
  assign bus.out_instr = fifo_instr[rd_ptr];
  assign bus.out_pc    = fifo_pc[rd_ptr];
  assign bus.mem_addr  = fetch_pc;
  assign busy          = (state == FETCH) || (state == DRAIN);
  assign halted        = (state == HALT);

  // Handshake, return-path qualification and the issue credit.
  // A redirect in the same cycle as a return wins, so that word is dropped.
  always_comb begin
    pop      = bus.out_valid && bus.out_ready;
    ret_live = inflight && (state == FETCH) && !bus.redirect_valid;
    halt_hit = ret_live && (bus.mem_rdata == HALT_WORD);
    push     = ret_live && !halt_hit;
    issue_en = (state == FETCH) && !bus.redirect_valid &&
               ((({1'b0, count} + {2'b00, inflight}) < 3'd2) || pop);
    flush    = bus.redirect_valid && busy;
    restart  = start && ((state == IDLE) || (state == HALT));
  end

  // Next-state logic: redirect > halt detection > start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (!bus.redirect_valid && halt_hit) state_nxt = DRAIN;
      DRAIN: begin
        if (bus.redirect_valid)                 state_nxt = FETCH;
        else if ((count - 2'(pop)) == 2'd0)     state_nxt = HALT;
      end
      HALT:    if (start) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Fetch PC and in-flight tracking; the memory has no enable, so only
  // cycles with issue_en count as real fetches.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue_en;
      if (issue_en) inflight_pc <= fetch_pc;
      if (restart)       fetch_pc <= RESET_PC;
      else if (flush)    fetch_pc <= bus.redirect_pc & ~ADDR_W'(3);
      else if (issue_en) fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  // Two-entry output FIFO; push and pop may coincide at any occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_instr <= '0;
      fifo_pc    <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= bus.mem_rdata;
        fifo_pc[wr_ptr]    <= inflight_pc;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a per-cycle vector table for start,
// stall/release and redirect, then hand-written halt, wrap, reset and
// redirect-vs-halt sequences. Memory model returns word i at byte 4*i.
module tb_fetch_controller;
  logic clk = 1'b0;
  logic reset, start, busy, halted;
  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  fetch_controller_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  fetch_controller dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr[9:2]];

  typedef struct {
    logic        start;
    logic        rv;
    logic [9:0]  rpc;
    logic        ready;
    logic        chk_data;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [9:0]  e_pc;
    logic [9:0]  e_addr;
    logic        e_busy;
    logic        e_halted;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!bus.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i;

    // start, stall for 5 cycles, release, then redirect to 0x103
    vecs[0]  = '{1, 0, 10'h000, 1, 1, 0, 32'd0,  10'h000, 10'h000, 0, 0};
    vecs[1]  = '{0, 0, 10'h000, 1, 0, 0, 32'd0,  10'h000, 10'h000, 1, 0};
    vecs[2]  = '{0, 0, 10'h000, 1, 0, 0, 32'd0,  10'h000, 10'h004, 1, 0};
    vecs[3]  = '{0, 0, 10'h000, 0, 1, 1, 32'd0,  10'h000, 10'h008, 1, 0};
    vecs[4]  = '{0, 0, 10'h000, 0, 1, 1, 32'd0,  10'h000, 10'h008, 1, 0};
    vecs[5]  = '{0, 0, 10'h000, 0, 1, 1, 32'd0,  10'h000, 10'h008, 1, 0};
    vecs[6]  = '{0, 0, 10'h000, 0, 1, 1, 32'd0,  10'h000, 10'h008, 1, 0};
    vecs[7]  = '{0, 0, 10'h000, 0, 1, 1, 32'd0,  10'h000, 10'h008, 1, 0};
    vecs[8]  = '{0, 0, 10'h000, 1, 1, 1, 32'd0,  10'h000, 10'h008, 1, 0};
    vecs[9]  = '{0, 0, 10'h000, 1, 1, 1, 32'd1,  10'h004, 10'h00C, 1, 0};
    vecs[10] = '{0, 0, 10'h000, 1, 1, 1, 32'd2,  10'h008, 10'h010, 1, 0};
    vecs[11] = '{0, 1, 10'h103, 1, 1, 1, 32'd3,  10'h00C, 10'h014, 1, 0};
    vecs[12] = '{0, 0, 10'h000, 1, 0, 0, 32'd0,  10'h000, 10'h100, 1, 0};
    vecs[13] = '{0, 0, 10'h000, 1, 0, 0, 32'd0,  10'h000, 10'h104, 1, 0};
    vecs[14] = '{0, 0, 10'h000, 1, 1, 1, 32'd64, 10'h100, 10'h108, 1, 0};
    vecs[15] = '{0, 0, 10'h000, 1, 1, 1, 32'd65, 10'h104, 10'h10C, 1, 0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (bus.out_valid !== vecs[i].e_valid || bus.mem_addr !== vecs[i].e_addr ||
          busy !== vecs[i].e_busy || halted !== vecs[i].e_halted ||
          (vecs[i].chk_data && (bus.out_instr !== vecs[i].e_instr ||
                                bus.out_pc !== vecs[i].e_pc))) begin
        n_bad++;
        $display("FAIL vec[%0d]: got v=%b addr=%h instr=%h pc=%h busy=%b halted=%b expected v=%b addr=%h instr=%h pc=%h busy=%b halted=%b",
                 i, bus.out_valid, bus.mem_addr, bus.out_instr, bus.out_pc, busy, halted,
                 vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc,
                 vecs[i].e_busy, vecs[i].e_halted);
      end
      start = vecs[i].start;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc = vecs[i].rpc;
      bus.out_ready = vecs[i].ready;
      @(negedge clk);
    end
    start = 1'b0; bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;

    // HALT_WORD at 0x10: words 0..3 delivered, nothing after, then restart
    mem[4] = 32'hFFFF_FFFF;
    do_reset();
    pulse_start();
    begin
      int got = 0;
      for (int c = 0; c < 30; c++) begin
        if (bus.out_valid) begin
          chk("halt_seq_pc", 32'(bus.out_pc), 32'(got * 4));
          chk("halt_seq_instr", bus.out_instr, 32'(got));
          got++;
        end
        @(negedge clk);
      end
      chk("halt_word_count", 32'(got), 32'd4);
    end
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    pulse_start();
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_addr", 32'(bus.mem_addr), 32'd0);
    wait_valid("restart_valid");
    chk("restart_pc", 32'(bus.out_pc), 32'd0);
    chk("restart_instr", bus.out_instr, 32'd0);
    mem[4] = 32'd4;

    // address wrap past 1020, then reset mid-stream
    do_reset();
    pulse_start();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h3F9;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    wait_valid("wrap_valid");
    chk("wrap_pc0", 32'(bus.out_pc), 32'h3F8);
    chk("wrap_instr0", bus.out_instr, 32'd254);
    @(negedge clk);
    chk("wrap_pc1", 32'(bus.out_pc), 32'h3FC);
    chk("wrap_instr1", bus.out_instr, 32'd255);
    @(negedge clk);
    chk("wrap_pc2", 32'(bus.out_pc), 32'h000);
    chk("wrap_instr2", bus.out_instr, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    chk("midrst_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    chk("midrst_idle_valid", 32'(bus.out_valid), 32'd0);
    pulse_start();
    wait_valid("midrst_restart_valid");
    chk("midrst_restart_pc", 32'(bus.out_pc), 32'd0);
    chk("midrst_restart_instr", bus.out_instr, 32'd0);
    @(negedge clk);
    chk("midrst_next_pc", 32'(bus.out_pc), 32'd4);
    chk("midrst_next_instr", bus.out_instr, 32'd1);

    // redirect arrives in the same cycle as a HALT_WORD return
    mem[2] = 32'hFFFF_FFFF;
    do_reset();
    pulse_start();
    begin
      int k = 0;
      while (bus.mem_addr !== 10'h00C && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("rvh_reach_addr", 32'(bus.mem_addr), 32'h00C);
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 10'h040;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    chk("rvh_halted", 32'(halted), 32'd0);
    chk("rvh_busy", 32'(busy), 32'd1);
    chk("rvh_addr", 32'(bus.mem_addr), 32'h040);
    chk("rvh_valid", 32'(bus.out_valid), 32'd0);
    wait_valid("rvh_target_valid");
    chk("rvh_target_pc", 32'(bus.out_pc), 32'h040);
    chk("rvh_target_instr", bus.out_instr, 32'd16);
    repeat (5) @(negedge clk);
    chk("rvh_still_running", 32'(halted), 32'd0);
    mem[2] = 32'd2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the synchronous-read InstructionMemory: drives its 10-bit byte address and captures the returned 32-bit word one cycle later.
- Buffers fetched words in a 2-entry FIFO and presents them to decode over a valid/ready handshake, with the PC of each word.
- Handles start, branch/jump redirect with squash of stale fetches, and halt detection.

Parameters:
- ADDR_W, 10, byte address width (memory depth 2^ADDR_W bytes).
- DATA_W, 32, instruction width.
- RESET_PC, 10'd0, first fetch address after start; must be word-aligned.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that ends fetching.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins fetching at RESET_PC from IDLE or HALT.
- mem_addr  out  ADDR_W  to memory ReadAddress; sampled by memory every rising edge.
- mem_rdata  in  DATA_W  from memory Instruction; valid the cycle after the address is sampled.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are forced to 0.
- out_valid  out  1  out_instr and out_pc are valid.
- out_ready  in  1  decode accepts the word.
- out_instr  out  DATA_W  fetched instruction.
- out_pc  out  ADDR_W  byte address of out_instr.
- busy  out  1  high in FETCH or DRAIN.
- halted  out  1  high in HALT.

Behaviour:
- Reset values: state IDLE, fetch_pc = RESET_PC, mem_addr = RESET_PC, FIFO empty, in-flight flag 0, out_valid 0, out_instr 0, out_pc 0, busy 0, halted 0.
- Reset mid-operation flushes everything. Memory data returning in the next cycle is discarded.
- mem_addr = fetch_pc register at all times. The memory has no enable, so a fetch is counted as issued only when issue_en is high.
- issue_en = (state == FETCH) && !redirect_valid && ((count + inflight < 2) || (out_valid && out_ready)).
- When issue_en is high at an edge:
  - inflight <= 1, inflight_pc <= fetch_pc.
  - fetch_pc <= fetch_pc + 4, modulo 2^ADDR_W (1020 wraps to 0).
- When issue_en is low, inflight <= 0 and fetch_pc holds.
- Return path: when inflight is high, mem_rdata is valid this cycle.
  - If the word is not squashed and is not HALT_WORD, write {mem_rdata, inflight_pc} into the FIFO at the edge.
  - FIFO can never overflow, guaranteed by the credit rule in issue_en.
- Latency: address issued in cycle t, data returns in cycle t+1, out_valid rises in cycle t+2. With out_ready held high, sustained throughput is 1 word/cycle.
- Handshake:
  - The FIFO head drives out_*; a pop occurs when out_valid && out_ready.
  - out_valid/out_instr/out_pc hold stable while out_valid && !out_ready.
  - Push and pop in the same cycle are allowed at any occupancy 0..2.
- States:
  - IDLE: no issue. start -> FETCH with fetch_pc <= RESET_PC. redirect ignored.
  - FETCH: issue per the rule above. A non-squashed return equal to HALT_WORD -> DRAIN; that word is not enqueued.
  - DRAIN: no issue, and any return is discarded. When the FIFO is empty (after final pop) -> HALT. redirect -> FETCH.
  - HALT: halted = 1. start -> FETCH at RESET_PC. redirect ignored.
- Redirect, in FETCH or DRAIN, on the edge where it is sampled:
  - FIFO flushed, so out_valid is 0 next cycle. A pop in the same cycle still counts as accepted by decode.
  - Any in-flight return in the next cycle is squashed.
  - fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}, state <= FETCH, no issue that cycle.
  - The first target word is issued the next cycle, and out_valid rises 3 cycles after the redirect edge.
- Priority: reset > redirect > halt detection > start.
- start while in FETCH/DRAIN is ignored.

Test Plan:
- Reset then start, out_ready=1, memory words 0..5 = 0x00000000+k -> mem_addr 0,4,8,...; first out_valid 2 cycles after first issue; out_pc 0,4,8 with matching words, one per cycle.
- out_ready held 0 for 5 cycles after first valid -> exactly 2 words buffered, mem_addr stalls at 8, out_instr stays word0; releasing ready yields words 0,1,2 back-to-back with no gap or duplicate.
- Redirect to 0x103 while FIFO holds 2 and one fetch in flight -> out_valid 0 next cycle, stale word never appears, next out_pc = 0x100.
- HALT_WORD at address 0x10, ready=1 -> words 0x0..0xC delivered, 0x10 and later never delivered, halted=1, busy=0; then start -> fetch restarts at RESET_PC.
- fetch_pc reaches 1020 -> next out_pc 0 (wrap); reset asserted mid-stream -> out_valid 0 next cycle, state IDLE, no stale word after a subsequent start.
- Redirect and HALT_WORD return in the same cycle -> redirect wins, state FETCH at target, halted stays 0.
